// File: rtl/alu_issue_stage.sv
// Execute-issue stage: resolves ALU operands (zero reg, X/M and M/W forwarding,
// immediate sign-extension) into a 2-entry skid buffer. Optional macro: ALU_ISSUE_PERF_EN.
module alu_issue_stage #(
    parameter int DW   = 32,
    parameter int IMMW = 17,
    parameter int RW   = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_aluop,
    input  logic [4:0]      in_shamt,
    input  logic [RW-1:0]   in_rs,
    input  logic [RW-1:0]   in_rt,
    input  logic [RW-1:0]   in_rd,
    input  logic [DW-1:0]   in_rs_data,
    input  logic [DW-1:0]   in_rt_data,
    input  logic [IMMW-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic            fwd_xm_en,
    input  logic [RW-1:0]   fwd_xm_rd,
    input  logic [DW-1:0]   fwd_xm_data,
    input  logic            fwd_mw_en,
    input  logic [RW-1:0]   fwd_mw_rd,
    input  logic [DW-1:0]   fwd_mw_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_operandA,
    output logic [DW-1:0]   out_operandB,
    output logic [4:0]      out_aluop,
    output logic [4:0]      out_shamt,
    output logic [RW-1:0]   out_rd
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_issue_cnt
`endif
);

    localparam int EW = 2*DW + 10 + RW;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    // Newest producer (X/M) wins; register 0 never forwards.
    function automatic logic [DW-1:0] resolve_src(
        input logic [RW-1:0] idx,
        input logic [DW-1:0] rf_data,
        input logic          xm_en,
        input logic [RW-1:0] xm_rd,
        input logic [DW-1:0] xm_data,
        input logic          mw_en,
        input logic [RW-1:0] mw_rd,
        input logic [DW-1:0] mw_data
    );
        logic [DW-1:0] res;
        if (idx == {RW{1'b0}}) begin
            res = {DW{1'b0}};
        end else if (xm_en && (xm_rd == idx)) begin
            res = xm_data;
        end else if (mw_en && (mw_rd == idx)) begin
            res = mw_data;
        end else begin
            res = rf_data;
        end
        return res;
    endfunction

    state_t          state_r, state_nxt_s;
    logic            out_valid_r, in_ready_r;
    logic [EW-1:0]   main_r, skid_r, entry_in_s;
    logic [DW-1:0]   op_a_s, op_b_s;
    logic            in_xfer_s, out_xfer_s;
    logic            load_main_in_s, load_main_skid_s, load_skid_s;

    assign in_xfer_s  = in_valid && in_ready_r;
    assign out_xfer_s = out_valid_r && out_ready;

    // Operand resolution on the incoming instruction.
    always_comb begin
        op_a_s = resolve_src(in_rs, in_rs_data, fwd_xm_en, fwd_xm_rd, fwd_xm_data,
                             fwd_mw_en, fwd_mw_rd, fwd_mw_data);
        if (in_use_imm) begin
            op_b_s = {{(DW-IMMW){in_imm[IMMW-1]}}, in_imm};
        end else begin
            op_b_s = resolve_src(in_rt, in_rt_data, fwd_xm_en, fwd_xm_rd, fwd_xm_data,
                                 fwd_mw_en, fwd_mw_rd, fwd_mw_data);
        end
        entry_in_s = {op_a_s, op_b_s, in_aluop, in_shamt, in_rd};
    end

    // Skid-buffer next state and entry load controls; flush overrides everything.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            EMPTY: begin
                if (in_xfer_s) begin
                    state_nxt_s    = ONE;
                    load_main_in_s = 1'b1;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            ONE: begin
                if (in_xfer_s && out_xfer_s) begin
                    state_nxt_s    = ONE;
                    load_main_in_s = 1'b1;
                end else if (in_xfer_s) begin
                    state_nxt_s = TWO;
                    load_skid_s = 1'b1;
                end else if (out_xfer_s) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = ONE;
                end
            end
            TWO: begin
                if (out_xfer_s) begin
                    state_nxt_s      = ONE;
                    load_main_skid_s = 1'b1;
                end else begin
                    state_nxt_s = TWO;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt_s      = EMPTY;
            load_main_in_s   = 1'b0;
            load_main_skid_s = 1'b0;
            load_skid_s      = 1'b0;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State register with registered handshake flags derived from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != EMPTY);
            in_ready_r  <= (state_nxt_s != TWO);
        end
    end

    // Main and skid entry data registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_r <= {EW{1'b0}};
            skid_r <= {EW{1'b0}};
        end else begin
            if (load_main_in_s) begin
                main_r <= entry_in_s;
            end else if (load_main_skid_s) begin
                main_r <= skid_r;
            end else begin
                main_r <= main_r;
            end
            if (load_skid_s) begin
                skid_r <= entry_in_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_operandA = main_r[EW-1 -: DW];
    assign out_operandB = main_r[EW-DW-1 -: DW];
    assign out_aluop    = main_r[RW+9 -: 5];
    assign out_shamt    = main_r[RW+4 -: 5];
    assign out_rd       = main_r[RW-1:0];

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_stall_cnt_r, perf_issue_cnt_r;

    // Free-running stall/issue counters; flush deliberately does not touch them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_stall_cnt_r <= 32'd0;
            perf_issue_cnt_r <= 32'd0;
        end else begin
            if (out_valid_r && !out_ready) begin
                perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
            end else begin
                perf_stall_cnt_r <= perf_stall_cnt_r;
            end
            if (out_xfer_s) begin
                perf_issue_cnt_r <= perf_issue_cnt_r + 32'd1;
            end else begin
                perf_issue_cnt_r <= perf_issue_cnt_r;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_r;
    assign perf_issue_cnt = perf_issue_cnt_r;
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed test-plan cases plus a random phase.
module tb_alu_issue_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  in_aluop = 5'd0, in_shamt = 5'd0, in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
    logic [31:0] in_rs_data = 32'd0, in_rt_data = 32'd0;
    logic [16:0] in_imm = 17'd0;
    logic        in_use_imm = 1'b0;
    logic        fwd_xm_en = 1'b0, fwd_mw_en = 1'b0;
    logic [4:0]  fwd_xm_rd = 5'd0, fwd_mw_rd = 5'd0;
    logic [31:0] fwd_xm_data = 32'd0, fwd_mw_data = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_operandA, out_operandB;
    logic [4:0]  out_aluop, out_shamt, out_rd;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_stall_cnt, perf_issue_cnt;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [4:0]  sh;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    alu_issue_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_shamt(in_shamt),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .fwd_xm_en(fwd_xm_en), .fwd_xm_rd(fwd_xm_rd), .fwd_xm_data(fwd_xm_data),
        .fwd_mw_en(fwd_mw_en), .fwd_mw_rd(fwd_mw_rd), .fwd_mw_data(fwd_mw_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_operandA(out_operandA), .out_operandB(out_operandB),
        .out_aluop(out_aluop), .out_shamt(out_shamt), .out_rd(out_rd)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt), .perf_issue_cnt(perf_issue_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference operand: later tests override earlier ones, so write in reverse priority.
    function automatic logic [31:0] model_src(input logic [4:0] r, input logic [31:0] rf);
        logic [31:0] v;
        v = rf;
        if (fwd_mw_en && fwd_mw_rd == r) v = fwd_mw_data;
        if (fwd_xm_en && fwd_xm_rd == r) v = fwd_xm_data;
        if (r == 5'd0) v = 32'd0;
        return v;
    endfunction

    function automatic exp_t model_entry();
        exp_t e;
        e.a  = model_src(in_rs, in_rs_data);
        e.b  = in_use_imm ? {{15{in_imm[16]}}, in_imm} : model_src(in_rt, in_rt_data);
        e.op = in_aluop;
        e.sh = in_shamt;
        e.rd = in_rd;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] op, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic [16:0] imm, input logic ui);
        in_valid = v; in_rs = rs; in_rt = rt; in_rd = rd; in_aluop = op;
        in_shamt = rd ^ 5'd9; in_rs_data = rsd; in_rt_data = rtd; in_imm = imm; in_use_imm = ui;
    endtask

    task automatic set_fwd(input logic xe, input logic [4:0] xr, input logic [31:0] xd,
                           input logic me, input logic [4:0] mr, input logic [31:0] md);
        fwd_xm_en = xe; fwd_xm_rd = xr; fwd_xm_data = xd;
        fwd_mw_en = me; fwd_mw_rd = mr; fwd_mw_data = md;
    endtask

    // One cycle at the negedge: retire/compare output, record accepted input, advance.
    task automatic step();
        exp_t e;
        if (out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                check("sb_spurious_output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_opA", out_operandA, e.a);
                check("sb_opB", out_operandB, e.b);
                check("sb_op", {27'd0, out_aluop}, {27'd0, e.op});
                check("sb_sh", {27'd0, out_shamt}, {27'd0, e.sh});
                check("sb_rd", {27'd0, out_rd}, {27'd0, e.rd});
            end
        end
        if (flush) sb.delete();
        if (in_valid && in_ready && !flush) sb.push_back(model_entry());
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_opA", out_operandA, 32'd0);
        check("rst_opB", out_operandB, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ALU_ISSUE_PERF_EN
        check("rst_perf_stall", perf_stall_cnt, 32'd0);
        check("rst_perf_issue", perf_issue_cnt, 32'd0);
`endif

        // Forwarding priority, 1-cycle latency
        out_ready = 1'b1;
        set_fwd(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        drive(1'b1, 5'd3, 5'd4, 5'd10, 5'd0, 32'd5, 32'd6, 17'd0, 1'b0);
        step();
        check("fwd_prio_valid", {31'd0, out_valid}, 32'd1);
        check("fwd_prio_opA", out_operandA, 32'h11);

        // Zero register, then M/W-only forwarding
        set_fwd(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0);
        drive(1'b1, 5'd0, 5'd1, 5'd11, 5'd1, 32'h1234, 32'd7, 17'd0, 1'b0);
        step();
        check("zero_reg_opA", out_operandA, 32'd0);
        set_fwd(1'b0, 5'd7, 32'h1, 1'b1, 5'd7, 32'hABCD);
        drive(1'b1, 5'd2, 5'd7, 5'd12, 5'd2, 32'd9, 32'h5555, 17'd0, 1'b0);
        step();
        check("mw_fwd_opB", out_operandB, 32'h0000ABCD);

        // Immediate sign-extension ignores forwarding
        set_fwd(1'b1, 5'd6, 32'h5, 1'b0, 5'd0, 32'd0);
        drive(1'b1, 5'd1, 5'd6, 5'd13, 5'd4, 32'd1, 32'd2, 17'h1FFFF, 1'b1);
        step();
        check("imm_neg_opB", out_operandB, 32'hFFFFFFFF);
        drive(1'b1, 5'd1, 5'd6, 5'd14, 5'd31, 32'd1, 32'd2, 17'h0FFFF, 1'b1);
        step();
        check("imm_pos_opB", out_operandB, 32'h0000FFFF);
        check("op_passthru", {27'd0, out_aluop}, 32'd31);
        in_valid = 1'b0;
        step();
        check("drain1_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: I0 in main, I1 in skid, I2 held upstream
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 5'd1, 5'd0, 32'hA0, 32'hB0, 17'd0, 1'b0);
        step();
        check("bp_ready_one", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 5'd1, 5'd2, 5'd2, 5'd1, 32'hA1, 32'hB1, 17'd0, 1'b0);
        step();
        check("bp_ready_two", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 5'd1, 5'd2, 5'd3, 5'd2, 32'hA2, 32'hB2, 17'd0, 1'b0);
        step();
        step();
        check("bp_stable_rd", {27'd0, out_rd}, 32'd1);
        check("bp_stable_opA", out_operandA, 32'hA0);
        check("bp_still_full", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        step();
        check("bp_drain_valid", {31'd0, out_valid}, 32'd0);
        check("bp_sb_empty", sb.size(), 32'd0);

        // Flush in TWO with an incoming instruction
        out_ready = 1'b0;
        drive(1'b1, 5'd3, 5'd4, 5'd20, 5'd3, 32'hC0, 32'hD0, 17'd0, 1'b0);
        step();
        drive(1'b1, 5'd3, 5'd4, 5'd21, 5'd3, 32'hC1, 32'hD1, 17'd0, 1'b0);
        step();
        flush = 1'b1;
        drive(1'b1, 5'd3, 5'd4, 5'd22, 5'd3, 32'hC2, 32'hD2, 17'd0, 1'b0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Asynchronous reset while in TWO, between clock edges
        out_ready = 1'b0;
        drive(1'b1, 5'd5, 5'd6, 5'd23, 5'd5, 32'hE0, 32'hF0, 17'd0, 1'b0);
        step();
        drive(1'b1, 5'd5, 5'd6, 5'd24, 5'd5, 32'hE1, 32'hF1, 17'd0, 1'b0);
        step();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_opA", out_operandA, 32'd0);
        check("arst_rd", {27'd0, out_rd}, 32'd0);
`ifdef ALU_ISSUE_PERF_EN
        check("arst_perf_stall", perf_stall_cnt, 32'd0);
        check("arst_perf_issue", perf_issue_cnt, 32'd0);
`endif
        #1 reset = 1'b0;
        sb.delete();
        @(negedge clock);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);

        // Random traffic with backpressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            set_fwd($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom), 5'($urandom), $urandom, $urandom, 17'($urandom),
                  $urandom_range(0, 3) == 0);
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 29) == 0;
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("final_sb_empty", sb.size(), 32'd0);
        check("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-issue stage directly upstream of the 32-bit behavioural ALU.
- Takes a decoded instruction plus register-file read data, resolves operands, and registers them.
- Operand resolution covers: the zero register, forwarding from the X/M and M/W stages, and immediate sign-extension.
- Presents `data_operandA`/`data_operandB`, `ctrl_ALUopcode` and `ctrl_shiftamt`-ready fields to the ALU through a valid/ready handshake with a 2-entry skid buffer.

Parameters:
- DW, 32, datapath width
- IMMW, 17, immediate field width, sign-extended to DW
- RW, 5, register-index width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept an instruction this cycle
- in_aluop  in  5  ALU opcode: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLL, 00101 SRA
- in_shamt  in  5  shift amount
- in_rs  in  RW  source A register index
- in_rt  in  RW  source B register index
- in_rd  in  RW  destination register index
- in_rs_data  in  DW  regfile read port A
- in_rt_data  in  DW  regfile read port B
- in_imm  in  IMMW  immediate
- in_use_imm  in  1  operand B = sign-extended immediate
- fwd_xm_en  in  1  X/M stage writes a register
- fwd_xm_rd  in  RW  X/M destination register index
- fwd_xm_data  in  DW  X/M result
- fwd_mw_en  in  1  M/W stage writes a register
- fwd_mw_rd  in  RW  M/W destination register index
- fwd_mw_data  in  DW  M/W result
- flush  in  1  squash all held and incoming instructions
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  downstream accepts
- out_operandA  out  DW  registered ALU operand A
- out_operandB  out  DW  registered ALU operand B
- out_aluop  out  5  registered opcode
- out_shamt  out  5  registered shift amount
- out_rd  out  RW  registered destination register

Behaviour:
- Clock and reset: single clock `clock`. Reset `reset` is asynchronous and active-high.
- Reset values: all registered outputs and both buffer entries clear to 0. out_valid = 0. in_ready = 1 in the first cycle after reset deasserts.
- Operand A resolution (combinational, on inputs):
  - in_rs == 0 -> 0.
  - Else fwd_xm_en && fwd_xm_rd == in_rs && fwd_xm_rd != 0 -> fwd_xm_data.
  - Else the same test against M/W -> fwd_mw_data.
  - Else in_rs_data.
  - X/M has priority over M/W.
- Operand B resolution:
  - in_use_imm = 1 -> {{(DW-IMMW){in_imm[IMMW-1]}}, in_imm}. Forwarding is ignored.
  - Otherwise same rules as A, using in_rt / in_rt_data.
- Opcode and shift pass-through: opcode and shamt are passed unchanged. Opcodes 00110-11111 are passed through unmodified; the stage does not trap.
- Buffer structure: main entry drives the out_* ports; the skid entry sits behind it.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Latency: 1 cycle from input transfer to out_valid when the buffer is empty.
- in_ready: registered; equals "skid entry empty". There is no combinational path from out_ready to in_ready.
- Skid buffer state machine (states EMPTY, ONE, TWO):
  - EMPTY: input -> ONE.
  - ONE:
    - input and output -> ONE; main is reloaded.
    - input only -> TWO; the new instruction goes to skid.
    - output only -> EMPTY.
  - TWO:
    - in_ready = 0.
    - output -> ONE; skid moves to main.
    - No output -> hold.
- Order: strictly in order; never drop or duplicate an instruction.
- Outputs while stalled: out_* stay stable while out_valid && !out_ready.
- Forwarding capture: forwarding values are sampled only at input-transfer time. A captured operand is never re-resolved while waiting in the buffer; the hazard unit guarantees this is safe.
- flush:
  - Synchronous. The next state is EMPTY, and the incoming instruction that cycle is discarded.
  - out_valid = 0 and in_ready = 1 next cycle.
  - Data registers may hold stale values.
  - flush overrides simultaneous input and output transfers.
- Reset mid-operation: immediate return to EMPTY and reset values, regardless of handshake state.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt [31:0], which increments each cycle out_valid && !out_ready.
  - Adds output perf_issue_cnt [31:0], which increments on each output transfer.
  - Both counters wrap modulo 2^32, clear on reset, and are unaffected by flush.
- Undefined: neither port nor any counter logic exists. Behaviour is otherwise identical.

Test Plan:
- Forwarding priority: in_rs=3, in_rs_data=5, fwd_xm(en,3,0x11), fwd_mw(en,3,0x22), in_valid=1, out_ready=1 -> next cycle out_operandA=0x11, out_valid=1.
- Zero register and M/W forwarding: in_rs=0, fwd_xm(en,0,0xFF) -> out_operandA=0. Then in_rt=7, only fwd_mw(en,7,0xABCD) -> out_operandB=0xABCD.
- Immediate sign-extension: in_use_imm=1, in_imm=17'h1FFFF, fwd_xm(en,in_rt,0x5) -> out_operandB=0xFFFFFFFF. With in_imm=17'h0FFFF -> 0x0000FFFF.
- Backpressure: hold out_ready=0 and present 3 back-to-back instructions I0, I1, I2 -> I0 on out_*, I1 in skid, in_ready=0 from cycle 2, I2 held upstream. Release out_ready -> I0, I1, I2 emerge in order, each exactly once.
- flush in state TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1. No flushed instruction appears afterwards.
- Async reset in state TWO between clock edges -> out_valid=0, out_* = 0 immediately. With ALU_ISSUE_PERF_EN, both counters read 0.
